// File: rtl/led_frame_sequencer.sv
// Streams an 8x8 pixel RAM to a WS2812B bit encoder in column-serpentine order, then holds the latch gap.
// Build option: define DOUBLE_BUFFER_EN to add a back bank that is swapped in when a frame starts.
module led_frame_sequencer #(
    parameter int NUM_ROWS     = 8,
    parameter int NUM_COLS     = 8,
    parameter int LATCH_CYCLES = 2000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_en,
    input  logic [5:0]  wr_addr,
    input  logic [23:0] wr_data,
    input  logic        frame_start,
    input  logic        pix_done,
    output logic        pix_load,
    output logic [23:0] pix_data,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  frame_count
);

    localparam int NUM_PIX = NUM_ROWS * NUM_COLS;
    localparam int CNT_W   = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
    localparam logic [5:0]       LAST_IDX   = 6'(NUM_PIX - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, LATCH} state_t;

    state_t           state, state_nxt;
    logic [5:0]       idx, idx_nxt;
    logic [CNT_W-1:0] latch_cnt, latch_cnt_nxt;
    logic             send_first;
    logic             count_en;
    logic [5:0]       rd_addr;
    logic [23:0]      rd_word;

    // Chain position k -> RAM address; odd columns run bottom-to-top.
    function automatic logic [5:0] chain_addr(input logic [5:0] k);
        int col;
        int pos;
        int row;
        col = int'(k) / NUM_ROWS;
        pos = int'(k) % NUM_ROWS;
        row = (col % 2 == 1) ? (NUM_ROWS - 1 - pos) : pos;
        return 6'(row * NUM_COLS + col);
    endfunction

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        latch_cnt_nxt = latch_cnt;
        count_en      = 1'b0;
        frame_done    = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    state_nxt = LOAD;
                    idx_nxt   = '0;
                end
            end
            LOAD: state_nxt = SEND;
            SEND: begin
                // The encoder's done line may still be stale in the first SEND cycle.
                if (pix_done && !send_first) begin
                    if (idx == LAST_IDX) begin
                        idx_nxt       = '0;
                        latch_cnt_nxt = '0;
                        state_nxt     = LATCH;
                    end else begin
                        idx_nxt   = idx + 6'd1;
                        state_nxt = LOAD;
                    end
                end
            end
            LATCH: begin
                if (latch_cnt == LATCH_LAST) begin
                    state_nxt  = IDLE;
                    frame_done = 1'b1;
                    count_en   = 1'b1;
                end else begin
                    latch_cnt_nxt = latch_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign pix_load = (state == LOAD);
    assign busy     = (state != IDLE);
    assign rd_addr  = chain_addr(idx_nxt);

`ifdef DOUBLE_BUFFER_EN
    logic [23:0] ram [0:2*NUM_PIX-1];
    logic        front, front_nxt;

    // Swap on the accepting edge so the frame reads everything written before it started.
    assign front_nxt = (state == IDLE && frame_start) ? ~front : front;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            front <= 1'b0;
        end else begin
            front <= front_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[{~front_nxt, wr_addr}] <= wr_data;
        end
    end

    assign rd_word = ram[{front_nxt, rd_addr}];
`else
    logic [23:0] ram [0:NUM_PIX-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[wr_addr] <= wr_data;
        end
    end

    assign rd_word = ram[rd_addr];
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            idx         <= '0;
            latch_cnt   <= '0;
            send_first  <= 1'b0;
            frame_count <= '0;
            pix_data    <= '0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            latch_cnt  <= latch_cnt_nxt;
            send_first <= (state == LOAD);
            if (count_en) begin
                frame_count <= frame_count + 8'd1;
            end
            // Capture reads the pre-write RAM word when a write hits the same address.
            if (state_nxt == LOAD) begin
                pix_data <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Self-checking bench for led_frame_sequencer: randomized writes and encoder timing against a chain-order model.
`timescale 1ns/1ps
module tb_led_frame_sequencer;

    localparam int LATCH  = 2000;
    localparam int WLATCH = 4;

    logic        clk = 1'b0;
    logic        reset_n, wr_en, frame_start, pix_done;
    logic [5:0]  wr_addr;
    logic [23:0] wr_data;
    logic        pix_load, busy, frame_done;
    logic [23:0] pix_data;
    logic [7:0]  frame_count;

    logic        w_reset_n, w_wr_en, w_frame_start, w_pix_done;
    logic [5:0]  w_wr_addr;
    logic [23:0] w_wr_data;
    logic        w_pix_load, w_busy, w_frame_done;
    logic [23:0] w_pix_data;
    logic [7:0]  w_frame_count;

    always #5 clk = ~clk;

    led_frame_sequencer #(.NUM_ROWS(8), .NUM_COLS(8), .LATCH_CYCLES(LATCH)) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_start(frame_start), .pix_done(pix_done), .pix_load(pix_load), .pix_data(pix_data),
        .busy(busy), .frame_done(frame_done), .frame_count(frame_count)
    );

    led_frame_sequencer #(.NUM_ROWS(8), .NUM_COLS(8), .LATCH_CYCLES(WLATCH)) dut_wrap (
        .clk(clk), .reset_n(w_reset_n), .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
        .frame_start(w_frame_start), .pix_done(w_pix_done), .pix_load(w_pix_load), .pix_data(w_pix_data),
        .busy(w_busy), .frame_done(w_frame_done), .frame_count(w_frame_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: chain order list, RAM bank(s), frame counter, one-cycle-delayed write commit.
    int          order [64];
    logic [23:0] bank [0:1][0:63];
    int          front = 0;
    int          mfc   = 0;
    bit          pend  = 0;
    int          pend_addr;
    logic [23:0] pend_data;
    int          burst_idx = 64;
    int          burst_kind = 0;
    logic [23:0] burst_val = '0;
    bit          rand_wr = 0;
    logic [23:0] last_word;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int wbank();
`ifdef DOUBLE_BUFFER_EN
        return 1 - front;
`else
        return 0;
`endif
    endfunction

    task automatic tick();
        @(negedge clk);
        pix_done = 1'b0;
    endtask

    task automatic post();
        if (pend) begin
            bank[wbank()][pend_addr] = pend_data;
            pend = 0;
        end
        wr_en = 1'b0;
        if (burst_idx < 64) begin
            wr_addr = 6'(burst_idx);
            case (burst_kind)
                0:       wr_data = 24'(burst_idx);
                1:       wr_data = 24'($urandom);
                default: wr_data = burst_val;
            endcase
            wr_en = 1'b1;
            burst_idx++;
        end else if (rand_wr && $urandom_range(3) == 0) begin
            wr_addr = 6'($urandom_range(63));
            wr_data = 24'($urandom);
            wr_en   = 1'b1;
        end
        if (wr_en) begin
            pend      = 1;
            pend_addr = int'(wr_addr);
            pend_data = wr_data;
        end
    endtask

    task automatic fill(input int kind, input logic [23:0] val);
        burst_kind = kind;
        burst_val  = val;
        burst_idx  = 0;
        while (burst_idx < 64) begin
            tick();
            post();
        end
        tick();
        post();
    endtask

    // Encoder model for one frame. poke_kind 1: frame_start pulse at SEND cycle 100; 2: write burst of 0xB00000.
    task automatic run_frame(input int dmin, input int dmax, input int poke_k, input int poke_kind,
                             input bit hold, input int abort_k);
        int d, w, gap, bad, nload;
        logic [23:0] held;
        nload = 0;
        frame_start = 1'b1;
        for (int k = 0; k < 64; k++) begin
            w = 0;
            tick();
            while (!pix_load && w < 50) begin
                post();
                tick();
                w++;
            end
            chk("load_latency", w, 0);
            if (!pix_load) begin
                frame_start = 1'b0;
                post();
                return;
            end
            nload++;
            if (k == 0 && !hold) frame_start = 1'b0;
`ifdef DOUBLE_BUFFER_EN
            if (k == 0) front = 1 - front;
`endif
            chk("pix_data", pix_data, bank[front][order[k]]);
            held      = pix_data;
            last_word = pix_data;
            post();
            if (k == abort_k) return;
            d = $urandom_range(dmax, dmin);
            if (k == poke_k) d = (poke_kind == 1) ? 120 : 80;
            bad = 0;
            for (int j = 1; j <= d; j++) begin
                tick();
                if (pix_load || !busy || pix_data !== held) bad++;
                if (j == 1 && dmin != dmax) pix_done = ($urandom_range(1) == 1);
                if (j == d) pix_done = 1'b1;
                if (k == poke_k && poke_kind == 1) frame_start = (j == 100);
                if (k == poke_k && poke_kind == 2 && j == 1) begin
                    burst_kind = 2;
                    burst_val  = 24'hB00000;
                    burst_idx  = 0;
                end
                post();
            end
            chk("send_hold", bad, 0);
        end
        gap = 0;
        bad = 0;
        do begin
            tick();
            gap++;
            if (pix_load || !busy) bad++;
            post();
        end while (!frame_done && gap < LATCH + 20);
        chk("latch_gap", gap, LATCH);
        chk("latch_quiet", bad, 0);
        chk("load_count", nload, 64);
        mfc = (mfc + 1) % 256;
        tick();
        chk("frame_count", frame_count, mfc);
        chk("done_pulse", frame_done, 0);
        chk("idle_busy", busy, 0);
        post();
        if (!hold) begin
            bad = 0;
            for (int i = 0; i < 5; i++) begin
                tick();
                if (pix_load || busy) bad++;
                post();
            end
            chk("no_requeue", bad, 0);
        end
    endtask

    task automatic main_seq();
        // Frame 1: RAM[a] = a, fixed 20-cycle encoder.
        fill(0, '0);
        run_frame(20, 20, -1, 0, 0, -1);
        chk("count_after_first", frame_count, 1);
        // Random data; frame_start pulsed deep inside a SEND phase must be ignored.
        fill(1, '0);
        run_frame(2, 8, 3, 1, 0, -1);
        // Held frame_start: two back-to-back frames with random background writes.
        rand_wr = 1;
        run_frame(2, 5, -1, 0, 1, -1);
        run_frame(2, 5, -1, 0, 0, -1);
        rand_wr = 0;
        // Reset mid-frame after word 10.
        run_frame(2, 6, -1, 0, 0, 10);
        tick();
        reset_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_load", pix_load, 0);
        chk("rst_data", pix_data, 0);
        chk("rst_count", frame_count, 0);
        chk("rst_done", frame_done, 0);
        post();
        for (int i = 0; i < 3; i++) begin
            tick();
            post();
        end
        reset_n = 1'b1;
        mfc   = 0;
        front = 0;
        run_frame(2, 6, -1, 0, 0, -1);
        chk("count_after_reset", frame_count, 1);
        // Mid-frame overwrite during word 5.
        fill(2, 24'h0000B0);
        run_frame(2, 4, 5, 2, 0, -1);
`ifdef DOUBLE_BUFFER_EN
        chk("frame1_last", last_word, 24'h0000B0);
`else
        chk("frame1_last", last_word, 24'hB00000);
`endif
        run_frame(2, 4, -1, 0, 0, -1);
        chk("frame2_last", last_word, 24'hB00000);
    endtask

    task automatic run_wrap();
        int nd, nl, cyc, bad;
        bit after;
        w_frame_start = 1'b1;
        w_pix_done    = 1'b1;
        nd = 0; nl = 0; cyc = 0; bad = 0; after = 0;
        while (nd < 256 && cyc < 256 * 400) begin
            @(negedge clk);
            cyc++;
            if (after) begin
                if (w_frame_count !== 8'(nd)) bad++;
                after = 0;
            end
            if (w_pix_load) nl++;
            if (w_frame_done) begin
                nd++;
                after = 1;
                if (nd == 256) w_frame_start = 1'b0;
            end
        end
        @(negedge clk);
        chk("wrap_count_each", bad, 0);
        chk("wrap_done_pulses", nd, 256);
        chk("wrap_loads", nl, 256 * 64);
        chk("wrap_frame_count", w_frame_count, 0);
        repeat (3) @(negedge clk);
        chk("wrap_idle", w_busy, 0);
    endtask

    initial begin
        int k;
        reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; frame_start = 1'b0; pix_done = 1'b0;
        w_reset_n = 1'b0; w_wr_en = 1'b0; w_wr_addr = '0; w_wr_data = '0; w_frame_start = 1'b0; w_pix_done = 1'b0;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            for (int r = 0; r < 8; r++) begin
                order[k] = ((c % 2 == 0) ? r : 7 - r) * 8 + c;
                k++;
            end
        end
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_load", pix_load, 0);
        chk("reset_data", pix_data, 0);
        chk("reset_done", frame_done, 0);
        chk("reset_count", frame_count, 0);
        reset_n   = 1'b1;
        w_reset_n = 1'b1;
        fork
            main_seq();
            run_wrap();
        join
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
